// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one word-wide memory port between instruction fetch and the LSU
//
// Purpose: grants the single memory port either to a 4-beat fetch burst that
// assembles a 128-bit bundle, or to a single-beat LSU load/store. LSU normally
// wins; once it has won STARVE_LIMIT times in a row with a fetch pending, the
// fetch is forced through.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   fetch_req/pc/flush           fetch request, bundle address, squash
//   fetch_bundle/valid           assembled bundle and its one-cycle strobe
//   lsu_rd_en/wr_en/addr/wr_data LSU load/store request
//   lsu_rd_data/done             load result and completion pulse
//   mem_addr/rd_en/wr_en/wr_data memory command (1-cycle read latency)
//   mem_rd_data                  memory read data
//   arb_stall                    pipeline stall while any request is outstanding
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_req,
  input  logic [31:0]  fetch_pc,
  input  logic         fetch_flush,
  output logic [127:0] fetch_bundle,
  output logic         fetch_valid,
  input  logic         lsu_rd_en,
  input  logic         lsu_wr_en,
  input  logic [31:0]  lsu_addr,
  input  logic [31:0]  lsu_wr_data,
  output logic [31:0]  lsu_rd_data,
  output logic         lsu_done,
  output logic [31:0]  mem_addr,
  output logic         mem_rd_en,
  output logic         mem_wr_en,
  output logic [31:0]  mem_wr_data,
  input  logic [31:0]  mem_rd_data,
  output logic         arb_stall
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    FETCH_RESP = 3'd2,
    LSU_RD     = 3'd3,
    LSU_RESP   = 3'd4,
    LSU_WR     = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_state_n;
  logic [1:0]     r_beat;
  logic [27:0]    r_pc_q;
  logic [31:0]    r_addr_q;
  logic [31:0]    r_data_q;
  logic [SW-1:0]  r_starve;
  logic [95:0]    r_buf;
  logic [127:0]   r_bundle;
  logic           r_fetch_valid;
  logic [31:0]    r_lsu_rd_data;
  logic           r_lsu_done;
  logic           w_fetch_ok;
  logic           w_lsu_ok;
  logic           w_grant_fetch;
  logic           w_grant_lsu;
  logic           w_unused;

  // A requester still holds its line during its own done/valid cycle; those
  // cycles must not be mistaken for a fresh request.
  assign w_fetch_ok = fetch_req & ~r_fetch_valid & ~fetch_flush;
  assign w_lsu_ok   = (lsu_rd_en | lsu_wr_en) & ~r_lsu_done;

  // Address low bits are discarded by construction.
  assign w_unused = ^{fetch_pc[3:0], lsu_addr[1:0]};

  always_comb begin
    w_state_n     = r_state;
    w_grant_fetch = 1'b0;
    w_grant_lsu   = 1'b0;
    mem_addr      = 32'd0;
    mem_rd_en     = 1'b0;
    mem_wr_en     = 1'b0;
    mem_wr_data   = 32'd0;
    case (r_state)
      IDLE: begin
        if (w_lsu_ok && !(w_fetch_ok && (r_starve == LIMIT))) begin
          w_grant_lsu = 1'b1;
          // Store wins when both enables are high; the load is dropped.
          w_state_n   = lsu_wr_en ? LSU_WR : LSU_RD;
        end else if (w_fetch_ok) begin
          w_grant_fetch = 1'b1;
          w_state_n     = FETCH;
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = {r_pc_q, r_beat, 2'b00};
        if (fetch_flush) begin
          w_state_n = IDLE;
        end else if (r_beat == 2'd3) begin
          w_state_n = FETCH_RESP;
        end
      end
      FETCH_RESP: w_state_n = IDLE;
      LSU_RD: begin
        mem_rd_en = 1'b1;
        mem_addr  = r_addr_q;
        w_state_n = LSU_RESP;
      end
      LSU_RESP: w_state_n = IDLE;
      LSU_WR: begin
        mem_wr_en   = 1'b1;
        mem_addr    = r_addr_q;
        mem_wr_data = r_data_q;
        w_state_n   = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_beat        <= 2'd0;
      r_pc_q        <= 28'd0;
      r_addr_q      <= 32'd0;
      r_data_q      <= 32'd0;
      r_starve      <= '0;
      r_buf         <= 96'd0;
      r_bundle      <= 128'd0;
      r_fetch_valid <= 1'b0;
      r_lsu_rd_data <= 32'd0;
      r_lsu_done    <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_fetch_valid <= (r_state == FETCH_RESP) && !fetch_flush;
      r_lsu_done    <= (r_state == LSU_RESP) || (r_state == LSU_WR);

      if (w_grant_fetch) begin
        r_pc_q <= fetch_pc[31:4];
        r_beat <= 2'd0;
      end
      if (w_grant_lsu) begin
        r_addr_q <= {lsu_addr[31:2], 2'b00};
        r_data_q <= lsu_wr_data;
      end

      // Words 0..2 are staged so a squashed burst never disturbs the
      // bundle presented to the fetch unit.
      if (r_state == FETCH) begin
        r_beat <= r_beat + 2'd1;
        case (r_beat)
          2'd1:    r_buf[31:0]  <= mem_rd_data;
          2'd2:    r_buf[63:32] <= mem_rd_data;
          2'd3:    r_buf[95:64] <= mem_rd_data;
          default: ;
        endcase
      end
      if ((r_state == FETCH_RESP) && !fetch_flush) begin
        r_bundle <= {mem_rd_data, r_buf};
      end
      if (r_state == LSU_RESP) begin
        r_lsu_rd_data <= mem_rd_data;
      end

      if (!fetch_req || w_grant_fetch) begin
        r_starve <= '0;
      end else if (w_grant_lsu && (r_starve != LIMIT)) begin
        r_starve <= r_starve + SW'(1);
      end
    end
  end

  assign fetch_bundle = r_bundle;
  assign fetch_valid  = r_fetch_valid;
  assign lsu_rd_data  = r_lsu_rd_data;
  assign lsu_done     = r_lsu_done;
  assign arb_stall    = (fetch_req & ~r_fetch_valid) |
                        ((lsu_rd_en | lsu_wr_en) & ~r_lsu_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         fetch_req;
  logic [31:0]  fetch_pc;
  logic         fetch_flush;
  logic [127:0] fetch_bundle;
  logic         fetch_valid;
  logic         lsu_rd_en;
  logic         lsu_wr_en;
  logic [31:0]  lsu_addr;
  logic [31:0]  lsu_wr_data;
  logic [31:0]  lsu_rd_data;
  logic         lsu_done;
  logic [31:0]  mem_addr;
  logic         mem_rd_en;
  logic         mem_wr_en;
  logic [31:0]  mem_wr_data;
  logic [31:0]  mem_rd_data;
  logic         arb_stall;

  int total = 0;
  int bad   = 0;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .fetch_req(fetch_req), .fetch_pc(fetch_pc), .fetch_flush(fetch_flush),
    .fetch_bundle(fetch_bundle), .fetch_valid(fetch_valid),
    .lsu_rd_en(lsu_rd_en), .lsu_wr_en(lsu_wr_en), .lsu_addr(lsu_addr),
    .lsu_wr_data(lsu_wr_data), .lsu_rd_data(lsu_rd_data), .lsu_done(lsu_done),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .arb_stall(arb_stall)
  );

  always #5 clk = ~clk;

  // Memory: word i holds 0xA000_0000 | i after reset; 1-cycle read latency.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | i;
    end else begin
      if (mem_wr_en) mem[mem_addr[9:2]] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= mem[mem_addr[9:2]];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [127:0] bundle_prev;
  logic [15:0]  log_bits;
  int           log_n;
  int           n_done;
  int           n_valid;

  initial begin
    rst = 1'b1; fetch_req = 1'b1; fetch_pc = 32'h0000_0104; fetch_flush = 1'b0;
    lsu_rd_en = 1'b1; lsu_wr_en = 1'b1; lsu_addr = 32'h0; lsu_wr_data = 32'h55;

    // Reset with all requests high
    tick(); tick();
    chk("rst_bundle", fetch_bundle, 128'd0);
    chk("rst_fvalid", fetch_valid, 1'b0);
    chk("rst_rdata", lsu_rd_data, 32'd0);
    chk("rst_done", lsu_done, 1'b0);
    chk("rst_maddr", mem_addr, 32'd0);
    chk("rst_mrd", mem_rd_en, 1'b0);
    chk("rst_mwr", mem_wr_en, 1'b0);
    chk("rst_mwdata", mem_wr_data, 32'd0);
    chk("rst_stall", arb_stall, 1'b1);

    // Fetch only: cycle 0 is the first cycle with rst low
    rst = 1'b0; lsu_rd_en = 1'b0; lsu_wr_en = 1'b0;
    tick();
    chk("f_b0_addr", mem_addr, 32'h100);
    chk("f_b0_rd", mem_rd_en, 1'b1);
    chk("f_stall", arb_stall, 1'b1);
    tick(); chk("f_b1_addr", mem_addr, 32'h104);
    tick(); chk("f_b2_addr", mem_addr, 32'h108);
    tick(); chk("f_b3_addr", mem_addr, 32'h10C);
    tick();
    chk("f_resp_rd", mem_rd_en, 1'b0);
    chk("f_resp_valid", fetch_valid, 1'b0);
    tick();
    chk("f_valid", fetch_valid, 1'b1);
    chk("f_bundle", fetch_bundle, {32'hA000_0043, 32'hA000_0042, 32'hA000_0041, 32'hA000_0040});
    chk("f_valid_stall", arb_stall, 1'b0);
    fetch_req = 1'b0;
    tick();
    chk("f_valid_pulse", fetch_valid, 1'b0);

    // Store 0xDEADBEEF to 0x40, then load 0x43
    lsu_wr_en = 1'b1; lsu_addr = 32'h40; lsu_wr_data = 32'hDEAD_BEEF;
    tick();
    chk("st_wr", mem_wr_en, 1'b1);
    chk("st_addr", mem_addr, 32'h40);
    chk("st_data", mem_wr_data, 32'hDEAD_BEEF);
    tick();
    chk("st_done", lsu_done, 1'b1);
    chk("st_done_stall", arb_stall, 1'b0);
    lsu_wr_en = 1'b0; lsu_rd_en = 1'b1; lsu_addr = 32'h43;
    tick();
    chk("ld_grant_rd", mem_rd_en, 1'b0);
    chk("ld_grant_done", lsu_done, 1'b0);
    tick();
    chk("ld_rd", mem_rd_en, 1'b1);
    chk("ld_addr", mem_addr, 32'h40);
    tick();
    chk("ld_resp_done", lsu_done, 1'b0);
    tick();
    chk("ld_done", lsu_done, 1'b1);
    chk("ld_data", lsu_rd_data, 32'hDEAD_BEEF);
    lsu_rd_en = 1'b0;
    tick();
    chk("ld_hold", lsu_rd_data, 32'hDEAD_BEEF);

    // Starvation: fetch held across 6 loads. Flush rides on lsu_done so the
    // fetch cannot take the IDLE slot that carries a completion pulse; the
    // limit alone must decide when it wins. Log: 0 = load issued, 1 = fetch.
    fetch_req = 1'b1; fetch_pc = 32'h200; lsu_rd_en = 1'b1; lsu_addr = 32'h40;
    log_bits = 16'd0; log_n = 0; n_done = 0; n_valid = 0;
    for (int c = 0; c < 60 && n_done < 6; c++) begin
      tick();
      if (mem_rd_en && mem_addr == 32'h40) begin
        log_bits = {log_bits[14:0], 1'b0}; log_n++;
      end
      if (mem_rd_en && mem_addr == 32'h200) begin
        log_bits = {log_bits[14:0], 1'b1}; log_n++;
      end
      if (fetch_valid) begin
        n_valid++;
        fetch_req = 1'b0;
        chk("sv_bundle", fetch_bundle, {32'hA000_0083, 32'hA000_0082, 32'hA000_0081, 32'hA000_0080});
      end
      if (lsu_done) begin
        n_done++;
        chk("sv_ld_data", lsu_rd_data, 32'hDEAD_BEEF);
        if (n_done == 6) lsu_rd_en = 1'b0;
      end
      fetch_flush = lsu_done;
    end
    fetch_flush = 1'b0;
    chk("sv_log_n", log_n, 7);
    chk("sv_order", log_bits[6:0], 7'b0000100);
    chk("sv_valid_n", n_valid, 1);
    chk("sv_done_n", n_done, 6);
    tick();

    // Flush during beat 2 with a store arriving
    bundle_prev = fetch_bundle;
    fetch_req = 1'b1; fetch_pc = 32'h300;
    tick(); chk("fl_b0_addr", mem_addr, 32'h300);
    tick(); chk("fl_b1_addr", mem_addr, 32'h304);
    tick();
    chk("fl_b2_addr", mem_addr, 32'h308);
    chk("fl_b2_rd", mem_rd_en, 1'b1);
    fetch_flush = 1'b1; fetch_req = 1'b0;
    lsu_wr_en = 1'b1; lsu_addr = 32'h80; lsu_wr_data = 32'h1234_5678;
    tick();
    fetch_flush = 1'b0;
    chk("fl_idle_rd", mem_rd_en, 1'b0);
    chk("fl_idle_valid", fetch_valid, 1'b0);
    tick();
    chk("fl_wr", mem_wr_en, 1'b1);
    chk("fl_wr_addr", mem_addr, 32'h80);
    chk("fl_wr_rd", mem_rd_en, 1'b0);
    chk("fl_wr_valid", fetch_valid, 1'b0);
    tick();
    chk("fl_done", lsu_done, 1'b1);
    chk("fl_done_valid", fetch_valid, 1'b0);
    chk("fl_bundle", fetch_bundle, bundle_prev);
    lsu_wr_en = 1'b0;
    tick();

    // Protocol error: load and store together
    lsu_rd_en = 1'b1; lsu_wr_en = 1'b1; lsu_addr = 32'h44; lsu_wr_data = 32'hCAFE_F00D;
    tick();
    chk("pe_wr", mem_wr_en, 1'b1);
    chk("pe_rd", mem_rd_en, 1'b0);
    chk("pe_addr", mem_addr, 32'h44);
    tick();
    chk("pe_done", lsu_done, 1'b1);
    chk("pe_done_rd", mem_rd_en, 1'b0);
    chk("pe_rdata", lsu_rd_data, 32'hDEAD_BEEF);
    lsu_rd_en = 1'b0; lsu_wr_en = 1'b0;
    tick();
    chk("pe_done_pulse", lsu_done, 1'b0);
    chk("pe_after_rd", mem_rd_en, 1'b0);
    chk("pe_after_wr", mem_wr_en, 1'b0);
    chk("pe_mem", mem[17], 32'hCAFE_F00D);

    // Reset in the middle of a load
    lsu_rd_en = 1'b1; lsu_addr = 32'h40;
    tick();
    chk("rm_rd", mem_rd_en, 1'b1);
    rst = 1'b1;
    tick();
    chk("rm_rd_off", mem_rd_en, 1'b0);
    chk("rm_done", lsu_done, 1'b0);
    rst = 1'b0; lsu_rd_en = 1'b0;
    tick();
    chk("rm_done2", lsu_done, 1'b0);
    chk("rm_rd_off2", mem_rd_en, 1'b0);
    chk("rm_rdata", lsu_rd_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported, word-wide main memory between the instruction-fetch path and the LSU. Fetch requests are served as 4-beat bursts that assemble the 128-bit instruction bundle; LSU loads and stores are single-beat transactions. It sits between `instruction_fetch`/`lsu` and `main_memory`. It drives a stall line into the pipeline stall network alongside `hazard_detection`.

## Interface
Parameters:
- STARVE_LIMIT, 4: maximum consecutive LSU grants while a fetch is pending before fetch is forced to win.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- fetch_req  in  1  level request for a bundle; held until fetch_valid.
- fetch_pc  in  32  bundle address; bits [3:0] ignored; sampled at grant.
- fetch_flush  in  1  branch squash; aborts an in-flight fetch.
- fetch_bundle  out  128  assembled bundle; word0 in [31:0] through word3 in [127:96].
- fetch_valid  out  1  one-cycle pulse; fetch_bundle is valid.
- lsu_rd_en  in  1  level load request; held until lsu_done.
- lsu_wr_en  in  1  level store request; held until lsu_done.
- lsu_addr  in  32  byte address; bits [1:0] forced to 0.
- lsu_wr_data  in  32  store data; sampled at grant.
- lsu_rd_data  out  32  load result; valid while lsu_done=1 and held afterwards.
- lsu_done  out  1  one-cycle pulse at completion of a load or store.
- mem_addr  out  32  memory word address (byte-addressed, word-aligned).
- mem_rd_en  out  1  memory read strobe.
- mem_wr_en  out  1  memory write strobe.
- mem_wr_data  out  32  memory write data.
- mem_rd_data  in  32  memory read data; valid the cycle after mem_rd_en.
- arb_stall  out  1  combinational: (fetch_req & ~fetch_valid) | ((lsu_rd_en | lsu_wr_en) & ~lsu_done).

## Operation
- **States:** IDLE, FETCH, FETCH_RESP, LSU_RD, LSU_RESP, LSU_WR.
- **Decoding:** memory-side outputs are decoded from the state, beat counter and the request registers captured at grant. All strobes are 0 in IDLE.
- **Request sampling in IDLE:**
  - fetch_req is ignored in any cycle where fetch_valid=1.
  - LSU requests are ignored in any cycle where lsu_done=1.
  - This prevents re-issue of a request the requester is about to drop.
- **Grant in IDLE:**
  - LSU wins over fetch unless starve_cnt == STARVE_LIMIT; in that case fetch wins.
  - lsu_wr_en and lsu_rd_en high together is a protocol error. The store is serviced, the load is dropped, and lsu_done pulses once.
- **starve_cnt (0..STARVE_LIMIT, saturating):**
  - +1 on each LSU grant while fetch_req=1.
  - Cleared on a fetch grant, and in any cycle fetch_req=0.
- **FETCH:** 4 cycles, beat b=0..3.
  - mem_rd_en=1 and mem_addr={pc_q[31:4], b[1:0], 2'b00}.
  - mem_rd_data is captured into bundle word b-1 on each edge for b≥1.
- **FETCH_RESP:** 1 cycle. Captures word 3. On the exit edge, fetch_valid is registered to 1 and the state returns to IDLE.
- **LSU_RD:** mem_rd_en=1, mem_addr=addr_q. Then LSU_RESP (1 cycle) captures mem_rd_data into lsu_rd_data and sets lsu_done for the next cycle.
- **LSU_WR:** 1 cycle with mem_wr_en=1, mem_addr=addr_q, mem_wr_data=data_q. Sets lsu_done for the next cycle.
- **fetch_flush:**
  - Asserted in FETCH or FETCH_RESP: the state goes to IDLE next cycle, no fetch_valid pulse, and fetch_bundle keeps its previous value.
  - Asserted in IDLE: a pending fetch_req is not granted that cycle.
  - LSU transactions are never aborted.
- fetch_bundle and lsu_rd_data hold their values until overwritten by the next completion.

## Timing
- **Reset:** state=IDLE, starve_cnt=0, beat=0, and every output is 0 (fetch_bundle, fetch_valid, lsu_rd_data, lsu_done, mem_*). arb_stall follows its inputs.
- **Reset mid-transaction:** abandons the transaction in the next cycle. No done or valid pulse, no further memory strobes.
- **Fetch latency:** request seen in IDLE at cycle 0 → FETCH cycles 1–4 → FETCH_RESP cycle 5 → fetch_valid=1 in cycle 6, with the state already IDLE.
- **Load latency:** IDLE cycle 0 → LSU_RD cycle 1 → LSU_RESP cycle 2 → lsu_done=1 with data in cycle 3.
- **Store latency:** IDLE cycle 0 → LSU_WR cycle 1 → lsu_done=1 in cycle 2.
- **Back-to-back:** a new grant may occur in the same IDLE cycle that carries a done/valid pulse for the other requester. There is no dead cycle beyond IDLE.
- **Memory model:** mem_rd_data is registered with a fixed 1-cycle read latency. Writes commit on the edge ending the mem_wr_en cycle.

## Test plan
- **Reset:** hold rst for 2 cycles with all requests high → all outputs 0; first grant occurs in the cycle after rst drops.
- **Fetch only:** fetch_pc=0x0000_0104, memory words 0x100..0x10C = A,B,C,D → mem_addr sequence 0x100, 0x104, 0x108, 0x10C in cycles 1–4; fetch_valid in cycle 6 with fetch_bundle={D,C,B,A}.
- **Store then load:** store 0xDEADBEEF to 0x40 (lsu_done in cycle 2), then load 0x43 → mem_addr=0x40, lsu_rd_data=0xDEADBEEF, lsu_done 3 cycles after the grant.
- **Starvation:** fetch_req held while the LSU issues 6 back-to-back loads, STARVE_LIMIT=4 → 4 loads granted, then the fetch, then the remaining 2 loads.
- **Flush:** fetch_flush asserted during FETCH beat 2 → no mem_rd_en after that cycle, no fetch_valid, fetch_bundle unchanged, and a pending LSU request is granted in the following IDLE cycle.
- **Protocol error:** lsu_rd_en and lsu_wr_en high together → exactly one LSU_WR cycle, one lsu_done pulse, no memory read.
